div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 99 +++++++++
 tb/tb_div_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider for RISC-V M-extension div/divu/rem/remu
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef DIV_FUNC
`define DIV_FUNC 3'b100
`endif
`ifndef DIVU_FUNC
`define DIVU_FUNC 3'b101
`endif
`ifndef REM_FUNC
`define REM_FUNC 3'b110
`endif
`ifndef REMU_FUNC
`define REMU_FUNC 3'b111
`endif

module div_unit #(
  parameter int DATA_W = `DATA_SIZE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        func_i,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o
);
  localparam int CW = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, next;
  logic [DATA_W-1:0] rem, quo, dvs, mag_a, mag_b, q_fix, r_fix;
  logic [DATA_W:0]   shifted, trial;
  logic [CW-1:0]     cnt;
  logic              is_rem, q_neg, r_neg;
  logic              sgn, sa, sb, dz, fast, accept;
  assign sgn    = ~func_i[0];
  assign sa     = sgn & op_a_i[DATA_W-1];
  assign sb     = sgn & op_b_i[DATA_W-1];
  assign mag_a  = sa ? -op_a_i : op_a_i;
  assign mag_b  = sb ? -op_b_i : op_b_i;
  assign dz     = op_b_i == '0;
  assign accept = state == IDLE && start_i && func_i[2] && !flush_i;
`ifdef DIV_FASTPATH_EN
  assign fast   = dz | (sgn && op_a_i == MIN && &op_b_i);
`else
  assign fast   = 1'b0;
`endif
  assign shifted = {rem, quo[DATA_W-1]};
  assign trial   = shifted - {1'b0, dvs};
  assign q_fix   = q_neg ? -quo : quo;
  assign r_fix   = r_neg ? -rem : rem;
  assign ready_o = state == IDLE;
  assign busy_o  = state == CALC || state == FIX;
  assign valid_o = state == DONE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else     state <= next;
  always_comb begin
    next = state;
    if (flush_i) next = IDLE;
    else
      unique case (state)
        IDLE: if (accept) next = fast ? FIX : CALC;
        CALC: if (cnt == CW'(DATA_W-1)) next = FIX;
        FIX:  next = DONE;
        DONE: next = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      cnt      <= '0;
      is_rem   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      result_o <= '0;
    end else if (accept) begin
      quo    <= fast ? (dz ? '1 : MIN) : mag_a;
      rem    <= (fast && dz) ? mag_a : '0;
      dvs    <= mag_b;
      cnt    <= '0;
      is_rem <= func_i[1];
      q_neg  <= (sa ^ sb) & ~dz;
      r_neg  <= sa;
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
      rem <= trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
      quo <= {quo[DATA_W-2:0], ~trial[DATA_W]};
    end else if (state == FIX && !flush_i)
      result_o <= is_rem ? r_fix : q_fix;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed table-driven check of div_unit results, latency and control corners.
module tb_div_unit;
`ifdef DIV_FASTPATH_EN
    localparam int SL = 2;
`else
    localparam int SL = 34;
`endif
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk = 0, rst = 1, start = 0, flush = 0;
    logic [2:0]  func = DIV;
    logic [31:0] op_a = 0, op_b = 0, result;
    logic        ready, busy, valid;
    int          errors = 0, checks = 0, n, cnt;
    logic [31:0] prev;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;
    vec_t v[14];

    div_unit #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .func_i(func), .op_a_i(op_a),
        .op_b_i(op_b), .flush_i(flush), .ready_o(ready), .busy_o(busy),
        .valid_o(valid), .result_o(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        func = f; op_a = a; op_b = b; start = 1;
        step(1);
        start = 0; func = DIVU; op_a = 32'hDEADBEEF; op_b = 32'h12345678;
    endtask

    task automatic wait_valid(input int from);
        n = from;
        while (!valid && n < 60) begin
            step(1);
            n++;
        end
    endtask

    task automatic no_valid(input string name, input int k);
        cnt = 0;
        repeat (k) begin
            step(1);
            if (valid) cnt++;
        end
        chk(name, cnt, 0);
    endtask

    initial begin
        v[0]  = '{DIV,  32'd100,        32'd7,          32'd14,         34};
        v[1]  = '{REM,  32'd100,        32'd7,          32'd2,          34};
        v[2]  = '{DIV,  -32'sd7,        32'd2,          32'hFFFFFFFD,   34};
        v[3]  = '{REM,  -32'sd7,        32'd2,          32'hFFFFFFFF,   34};
        v[4]  = '{DIVU, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   34};
        v[5]  = '{DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   SL};
        v[6]  = '{REMU, 32'd5,          32'd0,          32'd5,          SL};
        v[7]  = '{DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   SL};
        v[8]  = '{REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          SL};
        v[9]  = '{DIV,  -32'sd5,        32'd0,          32'hFFFFFFFF,   SL};
        v[10] = '{REM,  -32'sd5,        32'd0,          32'hFFFFFFFB,   SL};
        v[11] = '{REMU, 32'd7,          32'd3,          32'd1,          34};
        v[12] = '{DIVU, 32'd0,          32'd5,          32'd0,          34};
        v[13] = '{DIV,  32'd100,        -32'sd7,        32'hFFFFFFF2,   34};

        step(2);
        rst = 0;
        chk("reset_ctrl", {29'd0, ready, busy, valid}, 32'b100);
        chk("reset_result", result, 0);

        for (int i = 0; i < 14; i++) begin
            go(v[i].f, v[i].a, v[i].b);
            wait_valid(1);
            chk($sformatf("lat%0d", i), n, v[i].lat);
            chk($sformatf("res%0d", i), result, v[i].exp);
            step(1);
            chk($sformatf("pulse%0d", i), {30'd0, valid, ready}, 2'b01);
            chk($sformatf("hold%0d", i), result, v[i].exp);
        end
        prev = v[13].exp;

        func = 3'b000; op_a = 9; op_b = 3; start = 1;
        step(1);
        start = 0;
        chk("bad_func", {30'd0, ready, busy}, 2'b10);

        go(DIV, 32'd100, 32'd7);
        step(9);
        flush = 1;
        step(1);
        flush = 0;
        chk("flush_idle", {30'd0, ready, busy}, 2'b10);
        no_valid("flush_novalid", 40);
        chk("flush_result", result, prev);

        go(DIV, 32'd100, 32'd7);
        step(19);
        func = DIVU; op_a = 50; op_b = 5; start = 1;
        step(1);
        start = 0;
        wait_valid(21);
        chk("midstart_lat", n, 34);
        chk("midstart_res", result, 14);
        func = DIVU; op_a = 50; op_b = 5; start = 1;
        step(1);
        start = 0;
        chk("done_start", {30'd0, ready, busy}, 2'b10);
        chk("done_hold", result, 14);

        go(DIV, 32'd100, 32'd7);
        step(4);
        rst = 1;
        step(1);
        rst = 0;
        chk("rst_ctrl", {29'd0, ready, busy, valid}, 32'b100);
        chk("rst_result", result, 0);
        no_valid("rst_novalid", 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
